// File: rtl/request_tracker_if.sv
// Handshake bundle for request_tracker: per-channel strobes in, status and pulses out.
interface request_tracker_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] request;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] cancel;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] busy_start;
  logic [NUM_CH-1:0] early_accept;
  logic [NUM_CH-1:0] stray_accept;
  logic [NUM_CH-1:0] timeout;
  logic [15:0]       accepted_count;

  modport master (
    output request, accept, cancel,
    input  busy, busy_start, early_accept, stray_accept, timeout, accepted_count
  );

  modport slave (
    input  request, accept, cancel,
    output busy, busy_start, early_accept, stray_accept, timeout, accepted_count
  );
endinterface

// File: rtl/request_tracker.sv
// Per-channel request/accept tracker with early/stray/timeout flags and a
// saturating global count of accepted requests.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no pending request; accept here is stray, cancel ignored
// ST_WAIT | request pending; wait counter runs 1..TIMEOUT
// ST_BUSY | accepted; busy held for BUSY_LEN cycles via down-counter
module request_tracker #(
  parameter int NUM_CH    = 4,
  parameter int MIN_DELAY = 4,
  parameter int TIMEOUT   = 16,
  parameter int BUSY_LEN  = 8
) (
  input logic             clk,
  input logic             rst,
  request_tracker_if.slave bus
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BUSY_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BUSY = 2'd2
  } state_e;

  logic [NUM_CH-1:0][1:0]    state_q, state_d;
  logic [NUM_CH-1:0][WW-1:0] wait_q, wait_d;
  logic [NUM_CH-1:0][BW-1:0] bcnt_q, bcnt_d;
  logic [NUM_CH-1:0]         busy_q, busy_d;
  logic [NUM_CH-1:0]         start_q, start_d;
  logic [NUM_CH-1:0]         early_q, early_d;
  logic [NUM_CH-1:0]         stray_q, stray_d;
  logic [NUM_CH-1:0]         tmo_q, tmo_d;
  logic [NUM_CH-1:0]         take;
  logic [15:0]               count_q, count_d;
  logic [16:0]               count_sum;

  // State, counters and registered outputs; async reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      wait_q  <= '0;
      bcnt_q  <= '0;
      busy_q  <= '0;
      start_q <= '0;
      early_q <= '0;
      stray_q <= '0;
      tmo_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      bcnt_q  <= bcnt_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      early_q <= early_d;
      stray_q <= stray_d;
      tmo_q   <= tmo_d;
      count_q <= count_d;
    end
  end

  // Per-channel next-state logic; in WAIT cancel beats accept beats timeout.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    bcnt_d  = bcnt_q;
    busy_d  = '0;
    start_d = '0;
    early_d = '0;
    stray_d = '0;
    tmo_d   = '0;
    take    = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      case (state_e'(state_q[ch]))
        ST_IDLE: begin
          if (bus.accept[ch]) stray_d[ch] = 1'b1;
          if (bus.request[ch]) begin
            state_d[ch] = 2'(ST_WAIT);
            wait_d[ch]  = WW'(1);
          end
        end
        ST_WAIT: begin
          if (bus.cancel[ch]) begin
            state_d[ch] = 2'(ST_IDLE);
            wait_d[ch]  = '0;
          end else if (bus.accept[ch]) begin
            if (wait_q[ch] <= WW'(MIN_DELAY)) begin
              early_d[ch] = 1'b1;
              wait_d[ch]  = wait_q[ch] + WW'(1);
            end else begin
              state_d[ch] = 2'(ST_BUSY);
              wait_d[ch]  = '0;
              bcnt_d[ch]  = BW'(BUSY_LEN);
              start_d[ch] = 1'b1;
              take[ch]    = 1'b1;
            end
          end else if (wait_q[ch] == WW'(TIMEOUT)) begin
            state_d[ch] = 2'(ST_IDLE);
            wait_d[ch]  = '0;
            tmo_d[ch]   = 1'b1;
          end else begin
            wait_d[ch] = wait_q[ch] + WW'(1);
          end
        end
        ST_BUSY: begin
          // Loaded with BUSY_LEN on entry; the cycle that sees 1 is the last busy one.
          if (bcnt_q[ch] == BW'(1)) begin
            state_d[ch] = 2'(ST_IDLE);
            bcnt_d[ch]  = '0;
          end else begin
            bcnt_d[ch] = bcnt_q[ch] - BW'(1);
          end
        end
        default: begin
          state_d[ch] = 2'(ST_IDLE);
          wait_d[ch]  = '0;
          bcnt_d[ch]  = '0;
        end
      endcase
      busy_d[ch] = (state_e'(state_d[ch]) == ST_BUSY);
    end
  end

  // Saturating sum of all WAIT->BUSY transitions this cycle.
  always_comb begin
    count_sum = {1'b0, count_q};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      count_sum = count_sum + 17'(take[ch]);
    end
    count_d = count_sum[16] ? 16'hFFFF : count_sum[15:0];
  end

  assign bus.busy           = busy_q;
  assign bus.busy_start     = start_q;
  assign bus.early_accept   = early_q;
  assign bus.stray_accept   = stray_q;
  assign bus.timeout        = tmo_q;
  assign bus.accepted_count = count_q;

endmodule

// File: tb/tb_request_tracker.sv
// Directed, table-driven bench for request_tracker plus a small-parameter
// instance used to drive accepted_count into saturation.
module tb_request_tracker;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  request_tracker_if #(.NUM_CH(4))  bus ();
  request_tracker_if #(.NUM_CH(16)) sbus ();

  request_tracker #(
    .NUM_CH(4), .MIN_DELAY(4), .TIMEOUT(16), .BUSY_LEN(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  request_tracker #(
    .NUM_CH(16), .MIN_DELAY(0), .TIMEOUT(2), .BUSY_LEN(1)
  ) sat_dut (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  req;
    logic [3:0]  acc;
    logic [3:0]  can;
    logic [3:0]  busy;
    logic [3:0]  start;
    logic [3:0]  early;
    logic [3:0]  stray;
    logic [3:0]  tmo;
    logic [15:0] cnt;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];

  task automatic chk(input string nm, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int cyc, input logic [3:0] eb, input logic [3:0] es,
                         input logic [3:0] ee, input logic [3:0] ey, input logic [3:0] et,
                         input logic [15:0] ec);
    chk({tag, ".busy"},  cyc, 32'(bus.busy),           32'(eb));
    chk({tag, ".start"}, cyc, 32'(bus.busy_start),     32'(es));
    chk({tag, ".early"}, cyc, 32'(bus.early_accept),   32'(ee));
    chk({tag, ".stray"}, cyc, 32'(bus.stray_accept),   32'(ey));
    chk({tag, ".tmo"},   cyc, 32'(bus.timeout),        32'(et));
    chk({tag, ".cnt"},   cyc, 32'(bus.accepted_count), 32'(ec));
  endtask

  task automatic clr_in();
    bus.request  = '0;
    bus.accept   = '0;
    bus.cancel   = '0;
    sbus.request = '0;
    sbus.accept  = '0;
    sbus.cancel  = '0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b0;
    clr_in();

    // Expected table: all four channels exercised concurrently from cycle 0.
    for (int i = 0; i < NVEC; i++) begin
      vecs[i] = '0;
      vecs[i].cnt = 16'(int'(i >= 6) + int'(i >= 7) + int'(i >= 20) + int'(i >= 23));
      if (i >= 6 && i <= 13)  vecs[i].busy[0] = 1'b1;
      if (i >= 7 && i <= 14)  vecs[i].busy[1] = 1'b1;
      if (i >= 20)            vecs[i].busy[0] = 1'b1;
      if (i >= 23)            vecs[i].busy[3] = 1'b1;
    end
    vecs[0].req   = 4'b1111;
    vecs[3].acc   = 4'b0010;
    vecs[4].early = 4'b0010;
    vecs[5].acc   = 4'b0001;
    vecs[6].acc   = 4'b0110;
    vecs[6].can   = 4'b0100;
    vecs[6].start = 4'b0001;
    vecs[7].start = 4'b0010;
    vecs[8].acc   = 4'b0001;
    vecs[9].acc   = 4'b0100;
    vecs[10].req  = 4'b0001;
    vecs[10].stray = 4'b0100;
    vecs[11].can  = 4'b0100;
    vecs[14].req  = 4'b0001;
    vecs[17].tmo  = 4'b1000;
    vecs[17].req  = 4'b1000;
    vecs[19].acc  = 4'b0001;
    vecs[20].start = 4'b0001;
    vecs[22].acc  = 4'b1000;
    vecs[23].start = 4'b1000;

    // Reset state, checked while reset is held between edges.
    #2 rst = 1'b1;
    #1;
    chk_all("rst", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int i = 0; i < NVEC; i++) begin
      bus.request = vecs[i].req;
      bus.accept  = vecs[i].acc;
      bus.cancel  = vecs[i].can;
      chk_all("vec", i, vecs[i].busy, vecs[i].start, vecs[i].early,
              vecs[i].stray, vecs[i].tmo, vecs[i].cnt);
      step();
    end
    clr_in();
    repeat (10) step();
    chk_all("drain", 35, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd4);

    // All four channels accepted in the same cycle.
    bus.request = 4'b1111;
    step();
    bus.request = '0;
    repeat (4) step();
    bus.accept = 4'b1111;
    step();
    bus.accept = '0;
    chk_all("all4", 6, 4'b1111, 4'b1111, 4'h0, 4'h0, 4'h0, 16'd8);
    step();
    chk_all("all4", 7, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 16'd8);
    repeat (10) step();

    // Async reset mid-BUSY, then a fresh transaction.
    bus.request = 4'b0001;
    step();
    bus.request = '0;
    repeat (4) step();
    bus.accept = 4'b0001;
    step();
    bus.accept = '0;
    step();
    step();
    chk("prerst.busy", 8, 32'(bus.busy), 32'h1);
    #3 rst = 1'b1;
    #1;
    chk_all("midrst", 8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
    #2 rst = 1'b0;
    step();
    for (int c = 0; c <= 14; c++) begin
      bus.request = (c == 0) ? 4'b0001 : 4'b0000;
      bus.accept  = (c == 5) ? 4'b0001 : 4'b0000;
      chk_all("post", c, (c >= 6 && c <= 13) ? 4'b0001 : 4'b0000,
              (c == 6) ? 4'b0001 : 4'b0000, 4'h0, 4'h0, 4'h0,
              (c >= 6) ? 16'd1 : 16'd0);
      step();
    end
    clr_in();

    // Async reset at the last WAIT cycle must suppress the timeout pulse.
    bus.request = 4'b1000;
    step();
    bus.request = '0;
    repeat (15) step();
    #3 rst = 1'b1;
    #1;
    chk_all("wrst", 16, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
    #2 rst = 1'b0;
    step();
    chk_all("wrst", 17, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);

    // Saturation: 16 channels, 3 cycles per round, +16 per round.
    for (int r = 0; r < 4095; r++) begin
      sbus.request = '1;
      step();
      sbus.request = '0;
      sbus.accept  = '1;
      step();
      sbus.accept  = '0;
      if (r == 0) begin
        chk("sat.busy", r, 32'(sbus.busy), 32'hFFFF);
        chk("sat.cnt1", r, 32'(sbus.accepted_count), 32'd16);
      end
      step();
    end
    chk("sat.fff0", 4095, 32'(sbus.accepted_count), 32'hFFF0);
    for (int r = 0; r < 2; r++) begin
      sbus.request = '1;
      step();
      sbus.request = '0;
      sbus.accept  = '1;
      step();
      sbus.accept  = '0;
      step();
      chk("sat.ffff", 4096 + r, 32'(sbus.accepted_count), 32'hFFFF);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/request_tracker.md
REQUEST_TRACKER -- requirements
Module: request_tracker

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent request channels (1..16).
REQ-002 SHALL have parameter MIN_DELAY, default 4, cycles after a request during which accept is illegal.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum WAIT cycles before abandonment; MIN_DELAY < TIMEOUT is required.
REQ-004 SHALL have parameter BUSY_LEN, default 8, busy duration in cycles (>= 1).
REQ-005 SHALL have port clk  input  1  sole clock, all state on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port request  input  NUM_CH  per-channel request strobe.
REQ-008 SHALL have port accept  input  NUM_CH  per-channel accept strobe.
REQ-009 SHALL have port cancel  input  NUM_CH  per-channel cancel strobe.
REQ-010 SHALL have port busy  output  NUM_CH  channel busy, registered.
REQ-011 SHALL have port busy_start  output  NUM_CH  one-cycle pulse on the first busy cycle.
REQ-012 SHALL have port early_accept  output  NUM_CH  one-cycle pulse, accept arrived inside MIN_DELAY.
REQ-013 SHALL have port stray_accept  output  NUM_CH  one-cycle pulse, accept with no pending request.
REQ-014 SHALL have port timeout  output  NUM_CH  one-cycle pulse, pending request abandoned.
REQ-015 SHALL have port accepted_count  output  16  total accepted requests, all channels.

Function
REQ-016 SHALL run one FSM per channel with states IDLE, WAIT and BUSY, plus a wait counter of width $clog2(TIMEOUT+1) and a busy counter of width $clog2(BUSY_LEN+1).
REQ-017 SHALL, in IDLE with request=1, move to WAIT with wait counter = 1 in the first WAIT cycle.
REQ-018 SHALL ignore cancel in IDLE, and on accept in IDLE pulse stray_accept next cycle and stay IDLE.
REQ-019 SHALL increment the wait counter by 1 on every WAIT cycle that causes no transition.
REQ-020 SHALL, in WAIT, apply priority cancel > accept > timeout; request in WAIT is ignored.
REQ-021 SHALL, in WAIT on cancel=1, return to IDLE with no flag and no count.
REQ-022 SHALL, in WAIT on accept=1 with wait counter <= MIN_DELAY, pulse early_accept next cycle, stay WAIT and keep counting.
REQ-023 SHALL, in WAIT on accept=1 with wait counter > MIN_DELAY, move to BUSY; busy=1 and busy_start=1 in the following cycle.
REQ-024 SHALL, in WAIT with wait counter == TIMEOUT and neither cancel nor accept, pulse timeout next cycle and return to IDLE.
REQ-025 SHALL hold busy=1 for exactly BUSY_LEN cycles, then return to IDLE; request, accept and cancel are ignored in BUSY (no flags).
REQ-026 SHALL make busy rise only through REQ-023; busy_start equals the rising edge of busy.
REQ-027 SHALL allow a request in the first IDLE cycle after BUSY, WAIT or timeout (no dead cycle beyond the return to IDLE).
REQ-028 SHALL add to accepted_count, per cycle, the number of channels taking the WAIT->BUSY transition, saturating at 16'hFFFF.
REQ-029 SHALL keep channels fully independent; simultaneous events on different channels are each handled as though alone.

Reset
REQ-030 SHALL, while rst=1, force all channels to IDLE, all counters to 0, and all outputs (busy, pulses, accepted_count) to 0, regardless of clk.
REQ-031 SHALL, on rst asserted mid-WAIT or mid-BUSY, drop busy immediately and emit no timeout or busy_start for the aborted transaction.

Verification
REQ-032 SHALL cover: request ch0 at cycle 0, accept at cycle 5 -> busy[0]=1 and busy_start[0]=1 at cycle 6, busy[0] high cycles 6..13, accepted_count=1.
REQ-033 SHALL cover: request ch1 at 0, accept at 3, accept at 6 -> early_accept[1] pulse at 4, busy[1] rises at 7.
REQ-034 SHALL cover: request ch2 at 0, cancel and accept both at 6 -> IDLE at 7, busy[2] stays 0, accepted_count unchanged.
REQ-035 SHALL cover: request ch3 at 0, no accept or cancel -> timeout[3] pulse at cycle 17, ch3 back in IDLE.
REQ-036 SHALL cover: all four channels accepted in the same cycle -> accepted_count +4 in one step; preload near 16'hFFFF -> count saturates at 16'hFFFF.
REQ-037 SHALL cover: rst pulsed asynchronously between clk edges during BUSY -> busy drops at once, all outputs 0, a new request after reset behaves per REQ-032.
